// File: rtl/cp0.sv
// Coprocessor-0 exception/interrupt unit: SR, Cause, EPC, PRId, mfc0/mtc0 and the take-exception strobe.
// Optional macro CP0_PRID_EN: Addr 15 reads the PRId constant instead of zero.
module cp0 #(
  parameter int HWINT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         Addr,
  input  logic               WE,
  input  logic [31:0]        DataI,
  output logic [31:0]        DataO,
  input  logic [31:0]        PC,
  input  logic               BD,
  input  logic               ExcReq,
  input  logic [4:0]         ExcCode,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic               IntReq,
  output logic [31:0]        EPC
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HWINT_W-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [HWINT_W-1:0] cause_ip;
  logic [4:0]         cause_exc;
  logic [29:0]        epc_q;

  logic        int_hit;
  logic        exc_hit;
  logic [31:0] epc_next;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_hit  = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_hit  = ExcReq & ~sr_exl;
  assign IntReq   = int_hit | exc_hit;
  assign epc_next = BD ? (PC - 32'd4) : PC;

  assign sr_word    = {16'h0000, sr_im, 8'h00, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'h0000, cause_ip, 3'b000, cause_exc, 2'b00};
  assign EPC        = {epc_q, 2'b00};

  // Taking an exception swallows any eret or mtc0 on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc_q     <= 30'd0;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BD;
        cause_exc <= int_hit ? 5'd0 : ExcCode;
        epc_q     <= epc_next[31:2];
      end else begin
        if (WE && Addr == ADDR_SR) begin
          sr_im  <= DataI[15:10];
          sr_exl <= DataI[1];
          sr_ie  <= DataI[0];
        end
        if (WE && Addr == ADDR_EPC) begin
          epc_q <= DataI[31:2];
        end
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    DataO = 32'h0000_0000;
    case (Addr)
      ADDR_SR:    DataO = sr_word;
      ADDR_CAUSE: DataO = cause_word;
      ADDR_EPC:   DataO = EPC;
`ifdef CP0_PRID_EN
      ADDR_PRID:  DataO = 32'h4D49_5053;
`else
      ADDR_PRID:  DataO = 32'h0000_0000;
`endif
      default:    DataO = 32'h0000_0000;
    endcase
  end

endmodule
